// File: rtl/issue_queue_if.sv
// Fetch-side push handshake and issue-side head pair of the instruction-pair queue.
// master = fetch/issue environment, slave = the queue.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 8
`endif

interface issue_queue_if #(
  parameter int INST_W = `INST_WIDTH,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int ID_W   = `INSTRUCTION_ID_WIDTH
);
  logic              push_vld;
  logic              push_rdy;
  logic [INST_W-1:0] push_inst0;
  logic [INST_W-1:0] push_inst1;
  logic [ADDR_W-1:0] push_pc0;
  logic [ADDR_W-1:0] push_pc1;
  logic [ID_W-1:0]   push_id0;
  logic [ID_W-1:0]   push_id1;

  logic              issue_stall;
  logic [INST_W-1:0] head_inst0;
  logic [INST_W-1:0] head_inst1;
  logic [ADDR_W-1:0] head_pc0;
  logic [ADDR_W-1:0] head_pc1;
  logic [ID_W-1:0]   head_id0;
  logic [ID_W-1:0]   head_id1;

  modport master (
    output push_vld, push_inst0, push_inst1, push_pc0, push_pc1, push_id0, push_id1,
    output issue_stall,
    input  push_rdy,
    input  head_inst0, head_inst1, head_pc0, head_pc1, head_id0, head_id1
  );

  modport slave (
    input  push_vld, push_inst0, push_inst1, push_pc0, push_pc1, push_id0, push_id1,
    input  issue_stall,
    output push_rdy,
    output head_inst0, head_inst1, head_pc0, head_pc1, head_id0, head_id1
  );
endinterface

// File: rtl/issue_queue.sv
// Pair-wide circular instruction queue between IF/ID and the dual-issue stage,
// with flush and a saturating count of issue-stall cycles.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 8
`endif

module issue_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = `INST_WIDTH,
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int ID_W   = `INSTRUCTION_ID_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  issue_queue_if.slave             iq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cycles
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] inst0_mem [DEPTH];
  logic [INST_W-1:0] inst1_mem [DEPTH];
  logic [ADDR_W-1:0] pc0_mem   [DEPTH];
  logic [ADDR_W-1:0] pc1_mem   [DEPTH];
  logic [ID_W-1:0]   id0_mem   [DEPTH];
  logic [ID_W-1:0]   id1_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [15:0]      stall_cnt_reg, stall_cnt_next;

  logic not_empty;
  logic push_fire;
  logic pop_fire;

  // Ready looks only at the registered count: a same-cycle pop never frees a slot early.
  assign not_empty   = (count_reg != '0);
  assign iq.push_rdy = (count_reg != FULL_CNT) && !flush;
  assign push_fire   = iq.push_vld && iq.push_rdy;
  assign pop_fire    = not_empty && !iq.issue_stall && !flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    stall_cnt_next = stall_cnt_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
    // Stall accounting survives flush; only reset clears it.
    if (iq.issue_stall && !flush && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_next = stall_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Entry storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      inst0_mem[wr_ptr_reg] <= iq.push_inst0;
      inst1_mem[wr_ptr_reg] <= iq.push_inst1;
      pc0_mem[wr_ptr_reg]   <= iq.push_pc0;
      pc1_mem[wr_ptr_reg]   <= iq.push_pc1;
      id0_mem[wr_ptr_reg]   <= iq.push_id0;
      id1_mem[wr_ptr_reg]   <= iq.push_id1;
    end
  end

  // An empty queue presents an all-zero pair, which issue treats as NOPs.
  assign iq.head_inst0 = not_empty ? inst0_mem[rd_ptr_reg] : '0;
  assign iq.head_inst1 = not_empty ? inst1_mem[rd_ptr_reg] : '0;
  assign iq.head_pc0   = not_empty ? pc0_mem[rd_ptr_reg]   : '0;
  assign iq.head_pc1   = not_empty ? pc1_mem[rd_ptr_reg]   : '0;
  assign iq.head_id0   = not_empty ? id0_mem[rd_ptr_reg]   : '0;
  assign iq.head_id1   = not_empty ? id1_mem[rd_ptr_reg]   : '0;

  assign count        = count_reg;
  assign stall_cycles = stall_cnt_reg;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_reg <= FULL_CNT);
  a_ptr_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_ptr_reg - rd_ptr_reg) == count_reg[PTR_W-1:0]);
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Randomised and directed bench for issue_queue, checked every cycle against a
// queue-based model of the pair FIFO and stall counter.
`timescale 1ns/1ps
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_ID_WIDTH
`define INSTRUCTION_ID_WIDTH 8
`endif

module tb_issue_queue;
  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst0;
    logic [ADDR_W-1:0] pc0;
    logic [ID_W-1:0]   id0;
    logic [INST_W-1:0] inst1;
    logic [ADDR_W-1:0] pc1;
    logic [ID_W-1:0]   id1;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic [15:0]      stall_cycles;

  issue_queue_if #(.INST_W(INST_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) iq_bus ();

  issue_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .iq           (iq_bus),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  pair_t model_q[$];
  int    model_sc = 0;
  int    tests = 0;
  int    fails = 0;
  bit    verbose = 1'b1;
  bit    last_acc = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pair_t mk_pair(input int k);
    pair_t p;
    p.inst0 = 32'h1000_0001 + 32'(2 * k);
    p.inst1 = 32'h1000_0002 + 32'(2 * k);
    p.pc0   = 32'h0000_0100 + 32'(8 * k);
    p.pc1   = 32'h0000_0104 + 32'(8 * k);
    p.id0   = 8'(2 * k);
    p.id1   = 8'(2 * k + 1);
    return p;
  endfunction

  function automatic pair_t model_head();
    if (model_q.size() != 0) return model_q[0];
    return '0;
  endfunction

  function automatic logic model_rdy();
    return (model_q.size() != DEPTH) && !flush;
  endfunction

  function automatic pair_t dut_head();
    pair_t p;
    p.inst0 = iq_bus.head_inst0; p.pc0 = iq_bus.head_pc0; p.id0 = iq_bus.head_id0;
    p.inst1 = iq_bus.head_inst1; p.pc1 = iq_bus.head_pc1; p.id1 = iq_bus.head_id1;
    return p;
  endfunction

  function automatic pair_t push_pair();
    pair_t p;
    p.inst0 = iq_bus.push_inst0; p.pc0 = iq_bus.push_pc0; p.id0 = iq_bus.push_id0;
    p.inst1 = iq_bus.push_inst1; p.pc1 = iq_bus.push_pc1; p.id1 = iq_bus.push_id1;
    return p;
  endfunction

  task automatic drive(input pair_t p, input logic vld, input logic stl, input logic fl);
    iq_bus.push_vld   = vld;
    iq_bus.push_inst0 = p.inst0; iq_bus.push_pc0 = p.pc0; iq_bus.push_id0 = p.id0;
    iq_bus.push_inst1 = p.inst1; iq_bus.push_pc1 = p.pc1; iq_bus.push_id1 = p.id1;
    iq_bus.issue_stall = stl;
    flush = fl;
  endtask

  // One clock edge: advance the model with the inputs that were stable at the edge.
  task automatic tick();
    bit acc;
    pair_t p;
    @(posedge clk);
    acc = iq_bus.push_vld && model_rdy();
    p = push_pair();
    if (flush) begin
      model_q.delete();
    end else begin
      if ((model_q.size() != 0) && !iq_bus.issue_stall) void'(model_q.pop_front());
      if (acc) model_q.push_back(p);
    end
    if (iq_bus.issue_stall && !flush && (model_sc != 16'hFFFF)) model_sc++;
    if (acc && verbose)
      $display("[TB] push id0=%0d inst0=%h count_after=%0d", p.id0, p.inst0, model_q.size());
    last_acc = acc;
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 160'(count), 160'(model_q.size()));
      chk("push_rdy", 160'(iq_bus.push_rdy), 160'(model_rdy()));
      chk("head", 160'(dut_head()), 160'(model_head()));
      chk("stall_cycles", 160'(stall_cycles), 160'(model_sc));
    end
  end

  initial begin
    pair_t idle;
    pair_t cur;
    bit    pend;
    int    k;
    int    sc_before;
    idle = '0;
    drive(idle, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_count", 160'(count), 160'(0));
    chk("rst_head", 160'(dut_head()), 160'(0));
    chk("rst_rdy", 160'(iq_bus.push_rdy), 160'(1));
    chk("rst_stall", 160'(stall_cycles), 160'(0));
    #4 rst_n = 1'b1;

    // In-order flow with no stall: each pair heads the queue for one cycle
    for (int i = 0; i < 4; i++) begin
      drive(mk_pair(i), 1'b1, 1'b0, 1'b0);
      tick();
      chk("t1_inst0", 160'(iq_bus.head_inst0), 160'(32'h1000_0001 + 32'(2 * i)));
      chk("t1_inst1", 160'(iq_bus.head_inst1), 160'(32'h1000_0002 + 32'(2 * i)));
      chk("t1_count", 160'(count), 160'(1));
    end
    drive(idle, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_empty_head", 160'(iq_bus.head_inst0), 160'(0));
    chk("t1_empty_count", 160'(count), 160'(0));

    // Fill under stall; the 5th pair must wait
    k = 10;
    for (int i = 0; i < 5; i++) begin
      drive(mk_pair(k), 1'b1, 1'b1, 1'b0);
      tick();
      if (last_acc) k++;
    end
    chk("t2_count", 160'(count), 160'(4));
    chk("t2_rdy", 160'(iq_bus.push_rdy), 160'(0));
    chk("t2_head", 160'(iq_bus.head_inst0), 160'(32'h1000_0015));
    chk("t2_stall", 160'(stall_cycles), 160'(5));

    // One-cycle stall release: pop without same-cycle push
    drive(mk_pair(14), 1'b1, 1'b0, 1'b0);
    tick();
    chk("t3_count_pop", 160'(count), 160'(3));
    chk("t3_no_bypass", 160'(last_acc), 160'(0));
    chk("t3_head", 160'(iq_bus.head_id0), 160'(22));
    drive(mk_pair(14), 1'b1, 1'b1, 1'b0);
    tick();
    chk("t3_count_refill", 160'(count), 160'(4));
    drive(idle, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("t3_drained", 160'(count), 160'(0));

    // Steady push+pop at occupancy 1 across two pointer wraps
    for (int i = 0; i < 10; i++) begin
      drive(mk_pair(i), 1'b1, 1'b0, 1'b0);
      tick();
      chk("t4_id", 160'(iq_bus.head_id0), 160'(2 * i));
      chk("t4_count", 160'(count), 160'(1));
    end
    drive(idle, 1'b0, 1'b0, 1'b0);
    tick();

    // Flush with a simultaneous push at count 3
    for (int i = 0; i < 3; i++) begin
      drive(mk_pair(30 + i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("t5_count3", 160'(count), 160'(3));
    sc_before = int'(stall_cycles);
    drive(mk_pair(40), 1'b1, 1'b1, 1'b1);
    tick();
    chk("t5_count", 160'(count), 160'(0));
    chk("t5_head", 160'(dut_head()), 160'(0));
    chk("t5_stall", 160'(stall_cycles), 160'(sc_before));
    drive(idle, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t5_absent", 160'(count), 160'(0));

    // Random traffic; fetch holds a refused pair until it is accepted
    verbose = 1'b0;
    pend = 1'b0;
    cur = idle;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        cur = pair_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        pend = ($urandom_range(0, 3) != 0);
      end
      drive(cur, pend, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
      tick();
      if (last_acc) pend = 1'b0;
    end

    // Saturate the stall counter
    drive(idle, 1'b0, 1'b1, 1'b0);
    repeat (65540) tick();
    chk("sat_stall", 160'(stall_cycles), 160'(16'hFFFF));

    // Asynchronous reset in the middle of a cycle
    drive(mk_pair(50), 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    model_q.delete();
    model_sc = 0;
    #1;
    chk("arst_count", 160'(count), 160'(0));
    chk("arst_stall", 160'(stall_cycles), 160'(0));
    chk("arst_head", 160'(dut_head()), 160'(0));
    chk("arst_rdy", 160'(iq_bus.push_rdy), 160'(1));
    #3 rst_n = 1'b1;
    drive(mk_pair(60), 1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_head", 160'(iq_bus.head_id0), 160'(120));
    drive(idle, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
